// File: rtl/ctrl8085_pkg.sv
// ctrl8085_pkg: shared states, opcode constants and datapath select codes for the 8085-subset sequencer
package ctrl8085_pkg;
    typedef enum logic [2:0] {
        S_RST,
        S_FETCH,
        S_DECODE,
        S_OPND,
        S_EXEC,
        S_HALT
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_ADC = 3'd1;
    localparam logic [2:0] ALU_SUB = 3'd2;
    localparam logic [2:0] ALU_SBB = 3'd3;
    localparam logic [2:0] ALU_ANA = 3'd4;
    localparam logic [2:0] ALU_XRA = 3'd5;
    localparam logic [2:0] ALU_ORA = 3'd6;
    localparam logic [2:0] ALU_CMP = 3'd7;

    localparam logic [1:0] SEL_RF  = 2'd0;
    localparam logic [1:0] SEL_IMM = 2'd1;
    localparam logic [1:0] SEL_ACC = 2'd2;
    localparam logic [1:0] SEL_ALU = 2'd3;

    localparam logic [7:0] OP_NOP   = 8'h00;
    localparam logic [7:0] OP_HLT   = 8'h76;
    localparam logic [7:0] OP_JMP   = 8'hC3;
    localparam logic [7:0] OP_JZ    = 8'hCA;
    localparam logic [7:0] OP_JC    = 8'hDA;
    localparam logic [7:0] MVI_MASK = 8'hC7;
    localparam logic [7:0] MVI_BITS = 8'h06;
    localparam logic [1:0] CLS_MOV  = 2'b01;
    localparam logic [1:0] CLS_ALU  = 2'b10;

    localparam logic [2:0] REG_B = 3'd0;
    localparam logic [2:0] REG_C = 3'd1;
    localparam logic [2:0] REG_D = 3'd2;
    localparam logic [2:0] REG_E = 3'd3;
    localparam logic [2:0] REG_H = 3'd4;
    localparam logic [2:0] REG_L = 3'd5;
    localparam logic [2:0] REG_M = 3'd6;
    localparam logic [2:0] REG_A = 3'd7;
endpackage

// File: rtl/opcode_decode_8085.sv
// opcode_decode_8085: classifies an instruction byte into the supported 8085-subset groups
module opcode_decode_8085
    import ctrl8085_pkg::*;
(
    input  logic [7:0] ir,
    output logic       is_alu,
    output logic       is_mov,
    output logic       is_mvi,
    output logic       is_jmp,
    output logic       is_jz,
    output logic       is_jc,
    output logic       is_nop,
    output logic       is_hlt,
    output logic       two_byte,
    output logic       illegal,
    output logic [2:0] src,
    output logic [2:0] dst
);
    assign src      = ir[2:0];
    assign dst      = ir[5:3];
    assign is_nop   = ir == OP_NOP;
    assign is_hlt   = ir == OP_HLT;
    assign is_jmp   = ir == OP_JMP;
    assign is_jz    = ir == OP_JZ;
    assign is_jc    = ir == OP_JC;
    // memory operand M is not supported anywhere, so any 110 field disqualifies the opcode
    assign is_mvi   = (ir & MVI_MASK) == MVI_BITS && dst != REG_M;
    assign is_mov   = ir[7:6] == CLS_MOV && dst != REG_M && src != REG_M;
    assign is_alu   = ir[7:6] == CLS_ALU && src != REG_M;
    assign two_byte = is_mvi | is_jmp | is_jz | is_jc;
    assign illegal  = !(is_nop | is_hlt | two_byte | is_mov | is_alu);
endmodule

// File: rtl/ctrl_unit_8085_multi.sv
// ctrl_unit_8085_multi: multi-cycle fetch/decode/operand/execute sequencer for the 8085-subset datapath
module ctrl_unit_8085_multi
    import ctrl8085_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              z,
    input  logic              cy,
    output logic              mem_rd,
    output logic              pc_inc,
    output logic              pc_load,
    output logic [ADDR_W-1:0] pc_target,
    output logic [2:0]        rf_raddr,
    output logic              rf_we,
    output logic [2:0]        rf_waddr,
    output logic              acc_we,
    output logic              flag_we,
    output logic [2:0]        alu_op,
    output logic [1:0]        opnd_sel,
    output logic [DATA_W-1:0] imm_out,
    output logic              halt,
    output logic              illegal
);
    state_t            state, state_nx;
    logic [DATA_W-1:0] ir, imm;
    logic              d_alu, d_mov, d_mvi, d_jmp, d_jz, d_jc, d_nop, d_hlt, d_two, d_ill;
    logic [2:0]        src, dst;

    opcode_decode_8085 u_dec (
        .ir       (ir[7:0]),
        .is_alu   (d_alu),
        .is_mov   (d_mov),
        .is_mvi   (d_mvi),
        .is_jmp   (d_jmp),
        .is_jz    (d_jz),
        .is_jc    (d_jc),
        .is_nop   (d_nop),
        .is_hlt   (d_hlt),
        .two_byte (d_two),
        .illegal  (d_ill),
        .src      (src),
        .dst      (dst)
    );

    assign pc_target = imm[ADDR_W-1:0];
    assign imm_out   = imm;

    // state register; ir and imm capture program memory only in their fetch steps
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_RST;
            ir    <= '0;
            imm   <= '0;
        end else begin
            state <= state_nx;
            if (state == S_FETCH) ir <= mem_data;
            if (state == S_OPND) imm <= mem_data;
        end
    end

    // next-state and per-step control enables, all derived from registered ir/imm
    always_comb begin
        state_nx = state;
        mem_rd   = 1'b0;
        pc_inc   = 1'b0;
        pc_load  = 1'b0;
        rf_raddr = REG_B;
        rf_we    = 1'b0;
        rf_waddr = REG_B;
        acc_we   = 1'b0;
        flag_we  = 1'b0;
        alu_op   = ALU_ADD;
        opnd_sel = SEL_RF;
        halt     = 1'b0;
        illegal  = 1'b0;
        case (state)
            S_RST: state_nx = S_FETCH;
            S_FETCH: begin
                mem_rd   = 1'b1;
                pc_inc   = 1'b1;
                state_nx = S_DECODE;
            end
            S_DECODE: begin
                illegal  = d_ill;
                state_nx = d_hlt ? S_HALT : (d_nop | d_ill) ? S_FETCH : d_two ? S_OPND : S_EXEC;
            end
            S_OPND: begin
                mem_rd   = 1'b1;
                pc_inc   = 1'b1;
                state_nx = S_EXEC;
            end
            S_EXEC: begin
                state_nx = S_FETCH;
                if (d_alu | d_mov) begin
                    if (src == REG_A) opnd_sel = SEL_ACC;
                    else rf_raddr = src;
                end
                if (d_mvi) opnd_sel = SEL_IMM;
                if (d_alu) begin
                    alu_op  = dst;
                    flag_we = 1'b1;
                    acc_we  = dst != ALU_CMP;
                end
                if (d_mov | d_mvi) begin
                    if (dst == REG_A) acc_we = 1'b1;
                    else begin
                        rf_we    = 1'b1;
                        rf_waddr = dst;
                    end
                end
                pc_load = d_jmp | (d_jz & z) | (d_jc & cy);
            end
            S_HALT: halt = 1'b1;
            default: state_nx = S_RST;
        endcase
    end
endmodule

// File: tb/tb_ctrl_unit_8085_multi.sv
// tb_ctrl_unit_8085_multi: random program run against an instruction-level reference model
module tb_ctrl_unit_8085_multi;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] mem_data;
    logic       z = 1'b0;
    logic       cy = 1'b0;
    logic       mem_rd, pc_inc, pc_load, rf_we, acc_we, flag_we, halt, illegal;
    logic [7:0] pc_target, imm_out;
    logic [2:0] rf_raddr, rf_waddr, alu_op;
    logic [1:0] opnd_sel;
    logic [7:0] prog [256];
    logic [7:0] pc;
    logic [34:0] outs;
    int         n_chk = 0;
    int         n_fail = 0;
    bit         hold_zc = 1'b0;

    ctrl_unit_8085_multi dut (
        .clk       (clk),
        .reset     (reset),
        .mem_data  (mem_data),
        .z         (z),
        .cy        (cy),
        .mem_rd    (mem_rd),
        .pc_inc    (pc_inc),
        .pc_load   (pc_load),
        .pc_target (pc_target),
        .rf_raddr  (rf_raddr),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .acc_we    (acc_we),
        .flag_we   (flag_we),
        .alu_op    (alu_op),
        .opnd_sel  (opnd_sel),
        .imm_out   (imm_out),
        .halt      (halt),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    assign mem_data = prog[pc];
    assign outs = {mem_rd, pc_inc, pc_load, pc_target, rf_raddr, rf_we, rf_waddr,
                   acc_we, flag_we, alu_op, opnd_sel, imm_out, halt, illegal};

    // program counter of the surrounding datapath
    always @(posedge clk or posedge reset) begin
        if (reset) pc <= 8'd0;
        else if (pc_load) pc <= pc_target;
        else if (pc_inc) pc <= pc + 8'd1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // one instruction from the current pc: expected effects come from the opcode's class
    task automatic run_instr();
        logic [7:0] op, nxt, start, exp_pc, a_imm, a_tgt;
        logic [2:0] d, s, a_raddr, a_waddr, a_op;
        logic [1:0] a_sel;
        logic       lz, lc;
        bit         np, jm, jzb, jcb, mv, mo, al, il, two, ld_exp;
        int         n, c_inc, c_ld, c_rf, c_acc, c_fl, c_ill;
        start = pc;
        op = prog[start];
        nxt = prog[start + 8'd1];
        d = op[5:3];
        s = op[2:0];
        np = op == 8'h00;
        jm = op == 8'hC3;
        jzb = op == 8'hCA;
        jcb = op == 8'hDA;
        mv = op[7:6] == 2'd0 && s == 3'd6 && d != 3'd6;
        mo = op[7:6] == 2'd1 && d != 3'd6 && s != 3'd6;
        al = op[7:6] == 2'd2 && s != 3'd6;
        two = mv | jm | jzb | jcb;
        il = !(np | two | mo | al);
        n = two ? 4 : (mo | al) ? 3 : 2;
        c_inc = 0; c_ld = 0; c_rf = 0; c_acc = 0; c_fl = 0; c_ill = 0;
        lz = 0; lc = 0; a_imm = 0; a_tgt = 0; a_raddr = 0; a_waddr = 0; a_op = 0; a_sel = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (!hold_zc) begin
                z = 1'($urandom);
                cy = 1'($urandom);
            end
            #1;
            if (i == 0) chk("fetch", {mem_rd, pc_inc, halt}, 3'b110);
            chk("exclusive", {pc_inc & pc_load, rf_we & acc_we}, 2'b00);
            c_inc += int'(pc_inc);
            c_ld += int'(pc_load);
            c_rf += int'(rf_we);
            c_acc += int'(acc_we);
            c_fl += int'(flag_we);
            c_ill += int'(illegal);
            if (i == n - 1) begin
                lz = z; lc = cy;
                a_raddr = rf_raddr; a_waddr = rf_waddr; a_op = alu_op;
                a_sel = opnd_sel; a_imm = imm_out; a_tgt = pc_target;
            end
        end
        ld_exp = jm | (jzb & lz) | (jcb & lc);
        chk("pc_inc_cnt", c_inc, two ? 2 : 1);
        chk("pc_load_cnt", c_ld, ld_exp);
        chk("rf_we_cnt", c_rf, (mo | mv) && d != 3'd7);
        chk("acc_we_cnt", c_acc, (al && d != 3'd7) || ((mo | mv) && d == 3'd7));
        chk("flag_we_cnt", c_fl, al);
        chk("illegal_cnt", c_ill, il);
        if (al) chk("alu_op", a_op, d);
        if (al | mo) chk("opnd_sel", a_sel, s == 3'd7 ? 2 : 0);
        if ((al | mo) && s != 3'd7) chk("rf_raddr", a_raddr, s);
        if ((mo | mv) && d != 3'd7) chk("rf_waddr", a_waddr, d);
        if (mv) begin
            chk("mvi_sel", a_sel, 1);
            chk("imm_out", a_imm, nxt);
        end
        if (ld_exp) chk("pc_target", a_tgt, nxt);
        exp_pc = ld_exp ? nxt : 8'(start + (two ? 8'd2 : 8'd1));
        @(posedge clk);
        #1;
        chk("pc", pc, exp_pc);
    endtask

    // HLT at the current pc: holds halt without touching program memory, cleared by reset
    task automatic run_halt();
        int hc, rdc;
        prog[pc] = 8'h76;
        hc = 0;
        rdc = 0;
        @(negedge clk); #1;
        chk("hlt_fetch", {mem_rd, pc_inc}, 2'b11);
        @(negedge clk); #1;
        chk("hlt_decode", {halt, illegal, mem_rd}, 3'b000);
        repeat (20) begin
            @(negedge clk); #1;
            hc += int'(halt);
            rdc += int'(mem_rd | pc_inc | pc_load);
        end
        chk("halt_hold", hc, 20);
        chk("halt_no_rd", rdc, 0);
        reset = 1'b1;
        #1;
        chk("halt_reset", halt, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            prog[i] = 8'($urandom);
            if (prog[i] == 8'h76) prog[i] = 8'h00;
        end
        prog[0] = 8'h80; prog[1] = 8'h0E; prog[2] = 8'h2A;
        prog[3] = 8'hCA; prog[4] = 8'h10; prog[5] = 8'hCA; prog[6] = 8'h10;
        prog[16] = 8'hBA; prog[17] = 8'h7B; prog[18] = 8'h86;
        repeat (3) begin
            @(negedge clk); #1;
            chk("reset_outs", outs, 0);
        end
        reset = 1'b0;
        #1;
        chk("rst_state_outs", outs, 0);
        hold_zc = 1'b1;
        z = 1'b0; cy = 1'b1;
        run_instr();
        run_instr();
        run_instr();
        z = 1'b1; cy = 1'b0;
        run_instr();
        chk("jz_taken_pc", pc, 8'h10);
        run_instr();
        run_instr();
        run_instr();
        hold_zc = 1'b0;
        repeat (300) run_instr();
        run_halt();
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post_halt_rst", outs, 0);
        @(negedge clk); #1;
        chk("mid_fetch", {mem_rd, pc_inc, pc}, {2'b11, 8'h00});
        @(negedge clk); #1;
        @(negedge clk); #1;
        chk("mid_exec", {acc_we, flag_we, rf_raddr, alu_op}, 8'b11_000_000);
        reset = 1'b1;
        #1;
        chk("mid_reset_outs", outs, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mid_rst_state", outs, 0);
        run_instr();
        run_instr();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
